// File: rtl/ysyx_220053_alu_pkg.sv
// Shared definitions for the ALU scheduler slice.
// Contents: operand/opcode widths, ALU opcode encodings, requester index type.
// No ports (package).
package ysyx_220053_alu_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned OPW  = 4;

  // Opcode encodings; decoded only by the external ALU, passed through here.
  localparam logic [OPW-1:0] OpAdd   = 4'b0000;
  localparam logic [OPW-1:0] OpSll   = 4'b0001;
  localparam logic [OPW-1:0] OpSlt   = 4'b0010;
  localparam logic [OPW-1:0] OpSltu  = 4'b0011;
  localparam logic [OPW-1:0] OpXor   = 4'b0100;
  localparam logic [OPW-1:0] OpSrl   = 4'b0101;
  localparam logic [OPW-1:0] OpOr    = 4'b0110;
  localparam logic [OPW-1:0] OpAnd   = 4'b0111;
  localparam logic [OPW-1:0] OpSub   = 4'b1000;
  localparam logic [OPW-1:0] OpSra   = 4'b1101;
  localparam logic [OPW-1:0] OpPassb = 4'b1111;

  // Requester index: 0 = execute pipeline, 1 = auxiliary unit.
  typedef logic req_idx_t;

endpackage

// File: rtl/ysyx_220053_arb2.sv
// Two-way arbiter producing a one-hot grant.
// Ports:
//   clk_i, rst_i  clock / synchronous active-high reset (round-robin build only)
//   req_i[1:0]    request lines
//   en_i          grants allowed this cycle
//   gnt_o[1:0]    one-hot grant, only ever to an active request
// Macro ALU_SCHED_RR_EN: defined -> round-robin tie break with an internal prio
// register; undefined -> fixed priority, requester 0 wins ties, no state.
module ysyx_220053_arb2
  import ysyx_220053_alu_pkg::*;
(
`ifdef ALU_SCHED_RR_EN
  input  logic       clk_i,
  input  logic       rst_i,
`endif
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

`ifdef ALU_SCHED_RR_EN
  req_idx_t prio_q, prio_d;
  req_idx_t winner;

  always_comb begin
    winner = (req_i == 2'b11) ? prio_q : req_i[1];
    gnt_o  = 2'b00;
    if (en_i && (req_i != 2'b00)) begin
      gnt_o[winner] = 1'b1;
    end
  end

  // A grant always completes the handshake (it is only issued to a valid
  // requester), so the granted index hands priority to the other side.
  always_comb begin
    prio_d = prio_q;
    if (gnt_o[0]) begin
      prio_d = 1'b1;
    end else if (gnt_o[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  always_comb begin
    gnt_o[0] = en_i & req_i[0];
    gnt_o[1] = en_i & req_i[1] & ~req_i[0];
  end
`endif

endmodule

// File: rtl/ysyx_220053_alu_sched.sv
// Shares one external combinational 64-bit ALU between two requesters and
// captures the result in a one-entry valid/ready output register.
// Ports:
//   clk_i, rst_i                      clock / synchronous active-high reset
//   rN_valid_i/rN_ready_o             requester N handshake (N = 0, 1)
//   rN_a_i, rN_b_i, rN_op_i           requester N operands and opcode
//   alu_a_o, alu_b_o, alu_op_o        ALU inputs, driven from the winner
//   alu_result_i                      ALU combinational result
//   out_valid_o/out_ready_i           result register handshake
//   out_result_o, out_src_o           registered result and its requester
// Macro ALU_SCHED_RR_EN: round-robin arbitration when defined, fixed priority
// (requester 0 first) otherwise.
module ysyx_220053_alu_sched
  import ysyx_220053_alu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            r0_valid_i,
  output logic            r0_ready_o,
  input  logic [XLEN-1:0] r0_a_i,
  input  logic [XLEN-1:0] r0_b_i,
  input  logic [OPW-1:0]  r0_op_i,
  input  logic            r1_valid_i,
  output logic            r1_ready_o,
  input  logic [XLEN-1:0] r1_a_i,
  input  logic [XLEN-1:0] r1_b_i,
  input  logic [OPW-1:0]  r1_op_i,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [OPW-1:0]  alu_op_o,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_result_o,
  output logic            out_src_o
);

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  req_idx_t        out_src_q, out_src_d;
  logic            can_accept;
  logic [1:0]      gnt;
  logic            accept;

  // Register is empty or draining; reset blocks any handshake this cycle.
  assign can_accept = ~out_valid_q | out_ready_i;

  ysyx_220053_arb2 u_arb2 (
`ifdef ALU_SCHED_RR_EN
    .clk_i (clk_i),
    .rst_i (rst_i),
`endif
    .req_i ({r1_valid_i, r0_valid_i}),
    .en_i  (can_accept & ~rst_i),
    .gnt_o (gnt)
  );

  assign r0_ready_o = gnt[0];
  assign r1_ready_o = gnt[1];
  assign accept     = |gnt;

  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = '0;
    if (gnt[0]) begin
      alu_a_o  = r0_a_i;
      alu_b_o  = r0_b_i;
      alu_op_o = r0_op_i;
    end else if (gnt[1]) begin
      alu_a_o  = r1_a_i;
      alu_b_o  = r1_b_i;
      alu_op_o = r1_op_i;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_src_d    = out_src_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result_i;
      out_src_d    = gnt[1];
    end else if (out_ready_i) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_src_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_src_q    <= out_src_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_result_o = out_result_q;
  assign out_src_o    = out_src_q;

endmodule

// File: tb/tb_ysyx_220053_alu_sched.sv
// Directed testbench for ysyx_220053_alu_sched with a behavioural ALU.
module tb_ysyx_220053_alu_sched;
  import ysyx_220053_alu_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            r0_valid, r0_ready, r1_valid, r1_ready;
  logic [XLEN-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [OPW-1:0]  r0_op, r1_op;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [OPW-1:0]  alu_op;
  logic            out_valid, out_ready, out_src;
  logic [XLEN-1:0] out_result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ysyx_220053_alu_sched dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .r0_valid_i   (r0_valid),
    .r0_ready_o   (r0_ready),
    .r0_a_i       (r0_a),
    .r0_b_i       (r0_b),
    .r0_op_i      (r0_op),
    .r1_valid_i   (r1_valid),
    .r1_ready_o   (r1_ready),
    .r1_a_i       (r1_a),
    .r1_b_i       (r1_b),
    .r1_op_i      (r1_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_result_i (alu_result),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_src_o    (out_src)
  );

  // External ALU model.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OpAdd:   alu_result = alu_a + alu_b;
      OpSll:   alu_result = alu_a << alu_b[5:0];
      OpSlt:   alu_result = {63'd0, $signed(alu_a) < $signed(alu_b)};
      OpSltu:  alu_result = {63'd0, alu_a < alu_b};
      OpXor:   alu_result = alu_a ^ alu_b;
      OpSrl:   alu_result = alu_a >> alu_b[5:0];
      OpOr:    alu_result = alu_a | alu_b;
      OpAnd:   alu_result = alu_a & alu_b;
      OpSub:   alu_result = alu_a - alu_b;
      OpSra:   alu_result = $signed(alu_a) >>> alu_b[5:0];
      OpPassb: alu_result = alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1; out_ready = 1'b1;
    r0_a = 64'd1; r0_b = 64'd1; r0_op = OpAdd;
    r1_a = 64'd2; r1_b = 64'd2; r1_op = OpAdd;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({r0_ready, r1_ready} !== 2'b00) $display("FAIL reset_ready cyc%0d: got %b want 00", i, {r0_ready, r1_ready});
      else n_pass++;
    end
    r0_valid = 1'b0; r1_valid = 1'b0; rst = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_result !== 64'd0) $display("FAIL reset_out_result: got %h want 0", out_result);
    else n_pass++;
    n_checks++;
    if (out_src !== 1'b0) $display("FAIL reset_out_src: got %b want 0", out_src);
    else n_pass++;
    n_checks++;
    if ({alu_a, alu_b, alu_op} !== '0) $display("FAIL idle_alu_inputs: got %h/%h/%h want 0", alu_a, alu_b, alu_op);
    else n_pass++;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    r0_valid = 1'b1; r0_a = 64'd5; r0_b = 64'd3; r0_op = OpAdd;
    settle();
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b10) $display("FAIL single_ready: got %b want 10", {r0_ready, r1_ready});
    else n_pass++;
    n_checks++;
    if ({alu_a, alu_b, alu_op} !== {64'd5, 64'd3, 4'b0000}) $display("FAIL single_alu_in: got %h/%h/%h want 5/3/0", alu_a, alu_b, alu_op);
    else n_pass++;
    tick();
    r0_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_src, out_result} !== {1'b1, 1'b0, 64'd8}) $display("FAIL single_result: got v=%b s=%b r=%h want v=1 s=0 r=8", out_valid, out_src, out_result);
    else n_pass++;
    tick();
    // Drain with no new accept: valid drops, data held.
    n_checks++;
    if ({out_valid, out_src, out_result} !== {1'b0, 1'b0, 64'd8}) $display("FAIL single_drain: got v=%b s=%b r=%h want v=0 s=0 r=8", out_valid, out_src, out_result);
    else n_pass++;
  endtask

  task automatic test_tie();
    logic exp_src;
    logic [XLEN-1:0] exp_res;
    do_reset();
    out_ready = 1'b1;
    r0_valid = 1'b1; r0_a = 64'd10;   r0_b = 64'd3;    r0_op = OpSub;
    r1_valid = 1'b1; r1_a = 64'h0F0;  r1_b = 64'h0FF;  r1_op = OpXor;
    for (int i = 0; i < 4; i++) begin
      settle();
`ifdef ALU_SCHED_RR_EN
      exp_src = i[0];
`else
      exp_src = 1'b0;
`endif
      exp_res = exp_src ? 64'h0F : 64'd7;
      n_checks++;
      if ({r1_ready, r0_ready} !== {exp_src, ~exp_src}) $display("FAIL tie_grant cyc%0d: got r1r0=%b%b want src %0d", i, r1_ready, r0_ready, exp_src);
      else n_pass++;
      tick();
      n_checks++;
      if ({out_valid, out_src, out_result} !== {1'b1, exp_src, exp_res}) $display("FAIL tie_result cyc%0d: got v=%b s=%b r=%h want v=1 s=%b r=%h", i, out_valid, out_src, out_result, exp_src, exp_res);
      else n_pass++;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b1;
    r1_valid = 1'b1; r1_a = 64'h1234; r1_b = 64'hDEAD; r1_op = OpPassb;
    settle();
    n_checks++;
    if (r1_ready !== 1'b1) $display("FAIL bp_r1_accept: got %b want 1", r1_ready);
    else n_pass++;
    tick();
    r1_valid = 1'b0; out_ready = 1'b0;
    r0_valid = 1'b1; r0_a = 64'd1; r0_b = 64'd2; r0_op = OpAdd;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if ({out_valid, out_src, out_result} !== {1'b1, 1'b1, 64'hDEAD}) $display("FAIL bp_hold cyc%0d: got v=%b s=%b r=%h want v=1 s=1 r=dead", i, out_valid, out_src, out_result);
      else n_pass++;
      n_checks++;
      if ({r0_ready, r1_ready} !== 2'b00) $display("FAIL bp_ready cyc%0d: got %b want 00", i, {r0_ready, r1_ready});
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    settle();
    n_checks++;
    if (r0_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", r0_ready);
    else n_pass++;
    tick();
    r0_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_src, out_result} !== {1'b1, 1'b0, 64'd3}) $display("FAIL bp_release_result: got v=%b s=%b r=%h want v=1 s=0 r=3", out_valid, out_src, out_result);
    else n_pass++;
    tick();
  endtask

`ifndef ALU_SCHED_RR_EN
  task automatic test_fixed_prio();
    out_ready = 1'b1;
    r0_valid = 1'b1; r0_a = 64'd4;  r0_b = 64'd4; r0_op = OpOr;
    r1_valid = 1'b1; r1_a = 64'd9;  r1_b = 64'd6; r1_op = OpAnd;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if ({r0_ready, r1_ready} !== 2'b10) $display("FAIL fixed_grant cyc%0d: got %b want 10", i, {r0_ready, r1_ready});
      else n_pass++;
      tick();
    end
    r0_valid = 1'b0;
    settle();
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b01) $display("FAIL fixed_r1_grant: got %b want 01", {r0_ready, r1_ready});
    else n_pass++;
    tick();
    r1_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_src, out_result} !== {1'b1, 1'b1, 64'd0}) $display("FAIL fixed_r1_result: got v=%b s=%b r=%h want v=1 s=1 r=0", out_valid, out_src, out_result);
    else n_pass++;
    tick();
  endtask
`endif

  task automatic test_reset_mid_stall();
    out_ready = 1'b1;
    r0_valid = 1'b1; r0_a = 64'd5; r0_b = 64'd3; r0_op = OpAdd;
    tick();
    r0_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL mid_stall_valid: got %b want 1", out_valid);
    else n_pass++;
    r0_valid = 1'b1; r1_valid = 1'b1; out_ready = 1'b1; rst = 1'b1;
    settle();
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b00) $display("FAIL mid_rst_ready: got %b want 00", {r0_ready, r1_ready});
    else n_pass++;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({out_valid, out_result} !== {1'b0, 64'd0}) $display("FAIL mid_rst_out: got v=%b r=%h want v=0 r=0", out_valid, out_result);
    else n_pass++;
    // prio is back to 0, so a tie goes to requester 0.
    settle();
    n_checks++;
    if ({r0_ready, r1_ready} !== 2'b10) $display("FAIL mid_rst_prio: got %b want 10", {r0_ready, r1_ready});
    else n_pass++;
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_src, out_result} !== {1'b1, 1'b0, 64'd8}) $display("FAIL mid_rst_after: got v=%b s=%b r=%h want v=1 s=0 r=8", out_valid, out_src, out_result);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_a = '0; r0_b = '0; r0_op = '0;
    r1_a = '0; r1_b = '0; r1_op = '0;
    test_reset();
    test_single();
    test_tie();
    test_back_pressure();
`ifndef ALU_SCHED_RR_EN
    test_fixed_prio();
`endif
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
